// File: rtl/mem_port_arbiter_pkg.sv
// Shared types for the memory-port arbiter and its users: command kinds,
// arbiter state encoding and the processor-pool size default.
package mem_port_arbiter_pkg;

    localparam int PROC_COUNT       = 4;
    localparam int DEFAULT_MAX_HOLD = 16;

    typedef enum logic [1:0] {
        CMD_NONE,
        CMD_READ,
        CMD_WRITE
    } cmd_t;

    typedef enum logic {
        IDLE,
        GRANT
    } arb_state_t;

endpackage

// File: rtl/mem_port_arbiter_rr_pick.sv
// Combinational round-robin picker: first set request at or above ptr,
// wrapping modulo COUNT. Returns the one-hot winner and its index.
module rr_pick #(
    parameter  int COUNT = 4,
    localparam int IDX_W = $clog2(COUNT)
) (
    input  logic [COUNT-1:0] req,
    input  logic [IDX_W-1:0] ptr,
    output logic [COUNT-1:0] grant,
    output logic [IDX_W-1:0] index,
    output logic             valid
);

    // Walk offsets from farthest to nearest so the nearest hit is written last.
    always_comb begin
        int pos;
        pos   = 0;
        grant = '0;
        index = '0;
        valid = 1'b0;
        for (int i = COUNT - 1; i >= 0; i--) begin
            pos = (int'(ptr) + i) % COUNT;
            if (req[pos]) begin
                index        = pos[IDX_W-1:0];
                grant        = '0;
                grant[index] = 1'b1;
                valid        = 1'b1;
            end
        end
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Round-robin grant of the shared single-ported memory to the processor pool.
// Optional forced rotation after MAX_HOLD grant cycles: define ARB_TIMEOUT_EN.
module mem_port_arbiter
    import mem_port_arbiter_pkg::*;
#(
    parameter  int PORT_COUNT = PROC_COUNT,
    parameter  int MAX_HOLD   = DEFAULT_MAX_HOLD,
    localparam int SEL_W      = $clog2(PORT_COUNT)
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic [PORT_COUNT-1:0] i_req_rd,
    input  logic [PORT_COUNT-1:0] i_req_wr,
    output logic [PORT_COUNT-1:0] o_grant_rd,
    output logic [PORT_COUNT-1:0] o_grant_wr,
    output logic [SEL_W-1:0]      o_sel,
    output logic                  o_busy,
    output logic [PORT_COUNT-1:0] o_preempt
);

    if (PORT_COUNT < 2 || MAX_HOLD < 2) begin : g_bad_cfg
        $error("mem_port_arbiter: PORT_COUNT and MAX_HOLD must both be >= 2");
    end

    arb_state_t            state;
    cmd_t                  grant_type;
    logic [SEL_W-1:0]      ptr;
    logic [PORT_COUNT-1:0] req;
    logic [PORT_COUNT-1:0] pick_grant;
    logic [SEL_W-1:0]      pick_index;
    logic                  pick_valid;
    logic                  held;
    logic                  others;
    logic                  timeout_fire;
    logic [SEL_W-1:0]      next_ptr;

    assign req = i_req_rd | i_req_wr;

    rr_pick #(
        .COUNT (PORT_COUNT)
    ) u_pick (
        .req   (req),
        .ptr   (ptr),
        .grant (pick_grant),
        .index (pick_index),
        .valid (pick_valid)
    );

    // The grant type is frozen, so only the matching request bit keeps it alive.
    assign held     = (grant_type == CMD_WRITE) ? i_req_wr[o_sel] : i_req_rd[o_sel];
    assign others   = |(req & ~(o_grant_rd | o_grant_wr));
    assign next_ptr = (o_sel == SEL_W'(PORT_COUNT - 1)) ? '0 : o_sel + 1'b1;

`ifdef ARB_TIMEOUT_EN
    localparam int HOLD_W = $clog2(MAX_HOLD);
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(MAX_HOLD - 1);

    logic [HOLD_W-1:0] hold_cnt;

    assign timeout_fire = (state == GRANT) && (hold_cnt == HOLD_LAST) && others;

    // Counts granted cycles minus one; saturates when nobody else is waiting.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            hold_cnt <= '0;
        end else if (state == IDLE) begin
            hold_cnt <= '0;
        end else if (held && !timeout_fire && hold_cnt != HOLD_LAST) begin
            hold_cnt <= hold_cnt + 1'b1;
        end
    end
`else
    assign timeout_fire = 1'b0;
`endif

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state      <= IDLE;
            grant_type <= CMD_NONE;
            ptr        <= '0;
            o_sel      <= '0;
            o_busy     <= 1'b0;
            o_grant_rd <= '0;
            o_grant_wr <= '0;
            o_preempt  <= '0;
        end else begin
            o_preempt <= '0;
            case (state)
                IDLE: begin
                    if (pick_valid) begin
                        state  <= GRANT;
                        o_sel  <= pick_index;
                        o_busy <= 1'b1;
                        if (i_req_wr[pick_index]) begin
                            grant_type <= CMD_WRITE;
                            o_grant_wr <= pick_grant;
                        end else begin
                            grant_type <= CMD_READ;
                            o_grant_rd <= pick_grant;
                        end
                    end
                end
                GRANT: begin
                    // A voluntary release wins over a timeout in the same cycle.
                    if (!held || timeout_fire) begin
                        state      <= IDLE;
                        grant_type <= CMD_NONE;
                        ptr        <= next_ptr;
                        o_busy     <= 1'b0;
                        o_grant_rd <= '0;
                        o_grant_wr <= '0;
                        if (held) begin
                            o_preempt <= o_grant_rd | o_grant_wr;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed table-driven bench for mem_port_arbiter (PORT_COUNT=4, MAX_HOLD=4),
// with hand sequences for async reset mid-grant and the ARB_TIMEOUT_EN build.
module tb_mem_port_arbiter;

    localparam int N = 4;

    typedef struct {
        logic         rst;
        logic [N-1:0] rd;
        logic [N-1:0] wr;
        logic [N-1:0] grd;
        logic [N-1:0] gwr;
        logic [1:0]   sel;
        logic         busy;
    } vec_t;

    logic         clk;
    logic         rst;
    logic [N-1:0] req_rd;
    logic [N-1:0] req_wr;
    logic [N-1:0] grant_rd;
    logic [N-1:0] grant_wr;
    logic [1:0]   sel;
    logic         busy;
    logic [N-1:0] preempt;

    int   vectors;
    int   miscompares;
    vec_t vecs[$];

    mem_port_arbiter #(
        .PORT_COUNT (N),
        .MAX_HOLD   (4)
    ) dut (
        .i_clk      (clk),
        .i_rst      (rst),
        .i_req_rd   (req_rd),
        .i_req_wr   (req_wr),
        .o_grant_rd (grant_rd),
        .o_grant_wr (grant_wr),
        .o_sel      (sel),
        .o_busy     (busy),
        .o_preempt  (preempt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic addVec(input logic r, input logic [N-1:0] rd, input logic [N-1:0] wr,
                          input logic [N-1:0] grd, input logic [N-1:0] gwr,
                          input logic [1:0] s, input logic b);
        vec_t v;
        v.rst = r; v.rd = rd; v.wr = wr; v.grd = grd; v.gwr = gwr; v.sel = s; v.busy = b;
        vecs.push_back(v);
    endtask

    // Drive inputs just after an edge, then advance to just after the next edge.
    task automatic applyStimulus(input logic [N-1:0] rd, input logic [N-1:0] wr);
        req_rd = rd;
        req_wr = wr;
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string name, input logic [N-1:0] grd, input logic [N-1:0] gwr,
                               input logic [1:0] s, input logic b, input logic [N-1:0] pre);
        vectors++;
        if (grant_rd !== grd || grant_wr !== gwr || sel !== s || busy !== b || preempt !== pre) begin
            miscompares++;
            $display("[TB] FAIL %s: got grd=%b gwr=%b sel=%0d busy=%b pre=%b, want grd=%b gwr=%b sel=%0d busy=%b pre=%b",
                     name, grant_rd, grant_wr, sel, busy, preempt, grd, gwr, s, b, pre);
        end
        vectors++;
        if ((grant_rd & grant_wr) !== '0 || !$onehot0(grant_rd | grant_wr)) begin
            miscompares++;
            $display("[TB] FAIL %s onehot: got grd=%b gwr=%b, want at most one grant bit", name, grant_rd, grant_wr);
        end
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        rst    = 1'b1;
        req_rd = '0;
        req_wr = '0;
        @(posedge clk);
        #1;
        checkOutput("reset", 4'b0000, 4'b0000, 2'd0, 1'b0, 4'b0000);
        rst = 1'b0;

        // Basic: one port held 4 cycles, then released.
        for (int i = 0; i < 4; i++) addVec(0, 4'b0001, 4'b0000, 4'b0001, 4'b0000, 2'd0, 1);
        addVec(0, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 2'd0, 0);
        addVec(1, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 2'd0, 0);
        // Round-robin with all ports requesting, each releasing after 3 cycles.
        for (int p = 0; p < N; p++) begin
            logic [N-1:0] oh;
            oh = '0;
            oh[p] = 1'b1;
            for (int i = 0; i < 3; i++) addVec(0, 4'b1111, 4'b0000, oh, 4'b0000, 2'(p), 1);
            addVec(0, 4'b1111 & ~oh, 4'b0000, 4'b0000, 4'b0000, 2'(p), 0);
        end
        addVec(0, 4'b1111, 4'b0000, 4'b0001, 4'b0000, 2'd0, 1);
        addVec(0, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 2'd0, 0);
        // Write priority, frozen grant type; pointer 1 -> port 2.
        addVec(0, 4'b0100, 4'b0100, 4'b0000, 4'b0100, 2'd2, 1);
        addVec(0, 4'b0100, 4'b0100, 4'b0000, 4'b0100, 2'd2, 1);
        addVec(0, 4'b0000, 4'b0100, 4'b0000, 4'b0100, 2'd2, 1);
        addVec(0, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 2'd2, 0);
        // Pointer wrap from 3: port 0 before port 1.
        addVec(0, 4'b0011, 4'b0000, 4'b0001, 4'b0000, 2'd0, 1);
        addVec(0, 4'b0010, 4'b0000, 4'b0000, 4'b0000, 2'd0, 0);
        addVec(0, 4'b0010, 4'b0000, 4'b0010, 4'b0000, 2'd1, 1);
        addVec(0, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 2'd1, 0);
        // rd dropped with wr raised is a release; other-type requests ignored.
        addVec(0, 4'b0100, 4'b0000, 4'b0100, 4'b0000, 2'd2, 1);
        addVec(0, 4'b0000, 4'b0100, 4'b0000, 4'b0000, 2'd2, 0);
        addVec(0, 4'b0000, 4'b0100, 4'b0000, 4'b0100, 2'd2, 1);
        addVec(0, 4'b0100, 4'b0100, 4'b0000, 4'b0100, 2'd2, 1);
        addVec(0, 4'b0100, 4'b0000, 4'b0000, 4'b0000, 2'd2, 0);
        addVec(0, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 2'd2, 0);
        // Request that drops before being granted is not served.
        addVec(0, 4'b0001, 4'b0000, 4'b0001, 4'b0000, 2'd0, 1);
        addVec(0, 4'b0011, 4'b0000, 4'b0001, 4'b0000, 2'd0, 1);
        addVec(0, 4'b0001, 4'b0000, 4'b0001, 4'b0000, 2'd0, 1);
        addVec(0, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 2'd0, 0);
        addVec(0, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 2'd0, 0);
        // Leave the pointer at 2 for the reset test.
        addVec(0, 4'b0010, 4'b0000, 4'b0010, 4'b0000, 2'd1, 1);
        addVec(0, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 2'd1, 0);

        foreach (vecs[i]) begin
            rst = vecs[i].rst;
            applyStimulus(vecs[i].rd, vecs[i].wr);
            checkOutput($sformatf("vec%0d", i), vecs[i].grd, vecs[i].gwr, vecs[i].sel, vecs[i].busy, 4'b0000);
        end
        rst = 1'b0;

        // Reset mid-grant: grant drops immediately, pointer returns to 0.
        applyStimulus(4'b0000, 4'b0010);
        checkOutput("rst_setup", 4'b0000, 4'b0010, 2'd1, 1'b1, 4'b0000);
        rst = 1'b1;
        #1;
        checkOutput("rst_async", 4'b0000, 4'b0000, 2'd0, 1'b0, 4'b0000);
        @(posedge clk);
        #1;
        rst = 1'b0;
        applyStimulus(4'b0110, 4'b0000);
        checkOutput("rst_ptr0", 4'b0010, 4'b0000, 2'd1, 1'b1, 4'b0000);
        applyStimulus(4'b0000, 4'b0000);
        checkOutput("rst_release", 4'b0000, 4'b0000, 2'd1, 1'b0, 4'b0000);

        // Hold with a competitor arriving at grant cycle 1.
        rst = 1'b1;
        #1;
        rst = 1'b0;
        applyStimulus(4'b0001, 4'b0000);
        checkOutput("hold_c1", 4'b0001, 4'b0000, 2'd0, 1'b1, 4'b0000);
        for (int i = 2; i <= 4; i++) begin
            applyStimulus(4'b1001, 4'b0000);
            checkOutput($sformatf("hold_c%0d", i), 4'b0001, 4'b0000, 2'd0, 1'b1, 4'b0000);
        end
`ifdef ARB_TIMEOUT_EN
        applyStimulus(4'b1001, 4'b0000);
        checkOutput("timeout_drop", 4'b0000, 4'b0000, 2'd0, 1'b0, 4'b0001);
        applyStimulus(4'b1001, 4'b0000);
        checkOutput("timeout_next", 4'b1000, 4'b0000, 2'd3, 1'b1, 4'b0000);
        applyStimulus(4'b0000, 4'b0000);
        checkOutput("timeout_idle", 4'b0000, 4'b0000, 2'd3, 1'b0, 4'b0000);
`else
        for (int i = 5; i <= 6; i++) begin
            applyStimulus(4'b1001, 4'b0000);
            checkOutput($sformatf("hold_c%0d", i), 4'b0001, 4'b0000, 2'd0, 1'b1, 4'b0000);
        end
        applyStimulus(4'b0000, 4'b0000);
        checkOutput("hold_release", 4'b0000, 4'b0000, 2'd0, 1'b0, 4'b0000);
`endif

        // No competitor: grant holds well past MAX_HOLD in either build.
        rst = 1'b1;
        #1;
        rst = 1'b0;
        for (int i = 1; i <= 7; i++) begin
            applyStimulus(4'b0001, 4'b0000);
            checkOutput($sformatf("solo_c%0d", i), 4'b0001, 4'b0000, 2'd0, 1'b1, 4'b0000);
        end
        applyStimulus(4'b0000, 4'b0000);
        checkOutput("solo_release", 4'b0000, 4'b0000, 2'd0, 1'b0, 4'b0000);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
